// File: rtl/dmem_resp.sv
// Single-port data-memory responder: accepts one load/store, answers after LATENCY cycles.
// Optional build macro DMEM_RESP_ERR_EN enables out-of-range access faults.
`ifndef XLEN
`define XLEN 64
`endif

module dmem_resp #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [`XLEN-1:0]  req_addr,
  input  logic              req_wen,
  input  logic [`XLEN-1:0]  req_wdata,
  input  logic [7:0]        req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [`XLEN-1:0]  rsp_rdata,
  output logic              rsp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nx;
  logic [3:0]              cnt, cnt_nx;
  logic [`XLEN-1:0]        l_addr, l_wdata;
  logic                    l_wen;
  logic [7:0]              l_wmask;
  logic [`XLEN-1:0]        mem [2**DEPTH_LOG2];

  logic [`XLEN-1:0]        c_addr, c_wdata, off;
  logic                    c_wen;
  logic [7:0]              c_wmask;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    fault, accept, enter_rsp;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && (state == IDLE);
  assign enter_rsp = (state != RESP) && (state_nx == RESP);

  // With LATENCY==1 the accepting edge is also the RESP-entry edge, so the
  // access must use the live request rather than the latched copy.
  always_comb begin
    c_addr  = l_addr;
    c_wen   = l_wen;
    c_wdata = l_wdata;
    c_wmask = l_wmask;
    if (state == IDLE) begin
      c_addr  = req_addr;
      c_wen   = req_wen;
      c_wdata = req_wdata;
      c_wmask = req_wmask;
    end
  end

  assign off = c_addr - `XLEN'(BASE_ADDR);
  assign idx = off[DEPTH_LOG2+2:3];

`ifdef DMEM_RESP_ERR_EN
  assign fault = (c_addr < `XLEN'(BASE_ADDR)) || (off[`XLEN-1:DEPTH_LOG2+3] != '0);
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (req_valid) begin
        if (LATENCY == 1) state_nx = RESP;
        else begin
          state_nx = WAIT;
          cnt_nx   = 4'(LATENCY - 2);
        end
      end
      WAIT: if (cnt == 4'd0) state_nx = RESP;
            else cnt_nx = cnt - 4'd1;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      l_addr    <= '0;
      l_wen     <= 1'b0;
      l_wdata   <= '0;
      l_wmask   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        l_addr  <= req_addr;
        l_wen   <= req_wen;
        l_wdata <= req_wdata;
        l_wmask <= req_wmask;
      end
      if (enter_rsp) begin
        rsp_err   <= fault;
        rsp_rdata <= (c_wen || fault) ? '0 : mem[idx];
      end
    end
  end

  // Storage is deliberately not reset; writes are suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (enter_rsp && c_wen && !fault && !rst)
      for (int b = 0; b < 8; b++)
        if (c_wmask[b]) mem[idx][8*b +: 8] <= c_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_dmem_resp.sv
// Randomized self-checking bench for dmem_resp against a word-indexed reference memory.
`ifndef XLEN
`define XLEN 64
`endif

module tb_dmem_resp;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int LAT = 2;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_wen = 0, rsp_ready = 0, lv = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic [7:0]  req_wmask = 0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic        r1, v1, e1, r15, v15, e15;
  logic [63:0] d1, d15;

  dmem_resp #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_resp #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(lv), .req_ready(r1), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(v1),
    .rsp_ready(1'b1), .rsp_rdata(d1), .rsp_err(e1));

  dmem_resp #(.LATENCY(15)) dut15 (
    .clk(clk), .rst(rst), .req_valid(lv), .req_ready(r15), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(v15),
    .rsp_ready(1'b1), .rsp_rdata(d15), .rsp_err(e15));

  int tests = 0, fails = 0;
  logic [63:0] model [int];   // reference storage, keyed by word index
  int pool [8];

  function automatic int idx_of(logic [63:0] a);
    logic [63:0] d;
    d = a - BASE;
    return int'(d[14:3]);
  endfunction

  function automatic logic fault_of(logic [63:0] a);
`ifdef DMEM_RESP_ERR_EN
    return (a < BASE) || (a >= BASE + 64'h8000);
`else
    return (a == 64'h1) && (a == 64'h2);
`endif
  endfunction

  function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] wd, logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic issue(input logic [63:0] a, input logic w, input logic [63:0] wd, input logic [7:0] m);
    int g;
    @(negedge clk);
    req_valid = 1; req_addr = a; req_wen = w; req_wdata = wd; req_wmask = m;
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    req_wmask = 8'($urandom); req_wen = ~w;
  endtask

  // Called at the negedge after the accepting edge; lat counts edges from accept.
  task automatic await_rsp(output int lat, output logic [63:0] rd, output logic er);
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    rd = rsp_rdata; er = rsp_err;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic xfer(input logic [63:0] a, input logic w, input logic [63:0] wd, input logic [7:0] m,
                      output int lat, output logic [63:0] rd, output logic er);
    issue(a, w, wd, m);
    await_rsp(lat, rd, er);
    finish_rsp();
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    tests++; if (rsp_rdata !== 64'h0) begin fails++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    rst = 0;
  endtask

  task automatic test_store_load();
    int lat; logic [63:0] rd; logic er;
    xfer(64'h8000_0010, 1, 64'h1122334455667788, 8'hFF, lat, rd, er);
    model[2] = 64'h1122334455667788;
    tests++; if (lat !== LAT) begin fails++; $display("FAIL store_latency got %0d want %0d", lat, LAT); end
    tests++; if (rd !== 64'h0) begin fails++; $display("FAIL store_rdata got %h want 0", rd); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL store_err got %b want 0", er); end
    xfer(64'h8000_0010, 0, 64'h0, 8'h0, lat, rd, er);
    tests++; if (lat !== LAT) begin fails++; $display("FAIL load_latency got %0d want %0d", lat, LAT); end
    tests++; if (rd !== 64'h1122334455667788) begin fails++; $display("FAIL load_full got %h want 1122334455667788", rd); end
    xfer(64'h8000_0010, 1, 64'hAAAAAAAAAAAAAAAA, 8'h0F, lat, rd, er);
    model[2] = merge(model[2], 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    xfer(64'h8000_0010, 0, 64'h0, 8'h0, lat, rd, er);
    tests++; if (rd !== 64'h11223344AAAAAAAA) begin fails++; $display("FAIL load_partial got %h want 11223344aaaaaaaa", rd); end
    xfer(64'h8000_0017, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, lat, rd, er);
    xfer(64'h8000_0010, 0, 64'h0, 8'h0, lat, rd, er);
    tests++; if (rd !== model[2]) begin fails++; $display("FAIL zero_mask_store got %h want %h", rd, model[2]); end
  endtask

  task automatic test_backpressure();
    int lat; logic [63:0] rd; logic er;
    issue(64'h8000_0010, 0, 64'h0, 8'h0);
    await_rsp(lat, rd, er);
    tests++; if (rd !== model[2]) begin fails++; $display("FAIL bp_rdata got %h want %h", rd, model[2]); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid c%0d got %b want 1", c, rsp_valid); end
      tests++; if (rsp_rdata !== rd) begin fails++; $display("FAIL bp_hold_rdata c%0d got %h want %h", c, rsp_rdata, rd); end
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_ready c%0d got %b want 0", c, req_ready); end
    end
    finish_rsp();
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid got %b want 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    int lat, n; logic [63:0] rd; logic er;
    issue(64'h8000_0010, 0, 64'h0, 8'h0);
    await_rsp(lat, rd, er);
    rsp_ready = 1; req_valid = 1; req_addr = 64'h8000_0010; req_wen = 0;
    n = 1;
    @(posedge clk); @(negedge clk);
    tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_complete got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
    @(posedge clk); n++; @(negedge clk);
    req_valid = 0; rsp_ready = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); n++; @(negedge clk); end
    tests++; if (n !== LAT + 1) begin fails++; $display("FAIL b2b_spacing got %0d want %0d", n, LAT + 1); end
    tests++; if (rsp_rdata !== model[2]) begin fails++; $display("FAIL b2b_rdata got %h want %h", rsp_rdata, model[2]); end
    finish_rsp();
  endtask

  task automatic test_reset_wait();
    int lat; logic [63:0] rd; logic er;
    xfer(BASE, 1, 64'h0123456789ABCDEF, 8'hFF, lat, rd, er);
    model[0] = 64'h0123456789ABCDEF;
    issue(BASE, 1, 64'hFF, 8'hFF);
    rst = 1;
    @(posedge clk); @(negedge clk);
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL rst_wait_state got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
    rst = 0;
    xfer(BASE, 0, 64'h0, 8'h0, lat, rd, er);
    tests++; if (rd !== model[0]) begin fails++; $display("FAIL rst_wait_nowrite got %h want %h", rd, model[0]); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [63:0] rd, exp; logic er, fe;
    fe  = fault_of(64'h7000_0000);
    exp = fe ? 64'h0 : model[idx_of(64'h7000_0000)];
    xfer(64'h7000_0000, 0, 64'h0, 8'h0, lat, rd, er);
    tests++; if (er !== fe) begin fails++; $display("FAIL oob_err got %b want %b", er, fe); end
    tests++; if (rd !== exp) begin fails++; $display("FAIL oob_rdata got %h want %h", rd, exp); end
  endtask

  task automatic test_latency();
    int n, l1, l15;
    @(negedge clk);
    lv = 1; req_wen = 0; req_addr = BASE;
    @(posedge clk); n = 1;
    l1 = 0; l15 = 0;
    @(negedge clk); lv = 0;
    while (n < 20) begin
      if (v1 && l1 == 0) l1 = n;
      if (v15 && l15 == 0) l15 = n;
      @(posedge clk); n++; @(negedge clk);
    end
    tests++; if (l1 !== 1) begin fails++; $display("FAIL latency_1 got %0d want 1", l1); end
    tests++; if (l15 !== 15) begin fails++; $display("FAIL latency_15 got %0d want 15", l15); end
  endtask

  task automatic test_random();
    int lat, i, h; logic [63:0] a, wd, rd, exp; logic [7:0] m; logic w, er, fe;
    for (int k = 0; k < 8; k++) begin
      pool[k] = int'($urandom_range(0, 4095));
      wd = {$urandom, $urandom};
      xfer(BASE + 64'(pool[k]) * 8, 1, wd, 8'hFF, lat, rd, er);
      model[pool[k]] = wd;
    end
    for (int t = 0; t < 60; t++) begin
      a = BASE + 64'(pool[$urandom_range(0, 7)]) * 8 + 64'($urandom_range(0, 7));
`ifdef DMEM_RESP_ERR_EN
      if ($urandom_range(0, 5) == 0)
        a = ($urandom_range(0, 1) == 1) ? BASE - 64'($urandom_range(1, 100)) * 8
                                        : BASE + 64'h8000 + 64'($urandom_range(0, 100)) * 8;
`else
      if ($urandom_range(0, 3) == 0) a = a + 64'h8000 * 64'($urandom_range(1, 5));
`endif
      w  = 1'($urandom);
      wd = {$urandom, $urandom};
      m  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      fe = fault_of(a);
      i  = idx_of(a);
      exp = (w || fe) ? 64'h0 : model[i];
      if (w && !fe) model[i] = merge(model[i], wd, m);
      h = int'($urandom_range(0, 3));
      issue(a, w, wd, m);
      await_rsp(lat, rd, er);
      repeat (h) begin @(posedge clk); @(negedge clk); end
      tests++; if (rsp_rdata !== rd) begin fails++; $display("FAIL rnd_stable t%0d got %h want %h", t, rsp_rdata, rd); end
      finish_rsp();
      tests++; if (lat !== LAT) begin fails++; $display("FAIL rnd_latency t%0d got %0d want %0d", t, lat, LAT); end
      tests++; if (rd !== exp) begin fails++; $display("FAIL rnd_rdata t%0d addr %h got %h want %h", t, a, rd, exp); end
      tests++; if (er !== fe) begin fails++; $display("FAIL rnd_err t%0d addr %h got %b want %b", t, a, er, fe); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_backpressure();
    test_back_to_back();
    test_reset_wait();
    test_out_of_range();
    test_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
